// File: rtl/imm_extend_unit_if.sv
// imm_extend_unit_if: handshake bundle for the immediate extension unit.
//
// Producer side : in_valid / in_ready / in_data / in_mode
// Consumer side : out_valid / out_ready / out_data / out_count
//
// modport slave  : the extension unit itself
// modport master : whoever drives immediates and consumes results
interface imm_extend_unit_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_count;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_count
  );

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_count
  );

endinterface

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: extends a raw IN_W-bit immediate to OUT_W bits and queues the
// result in a 2-entry in-order buffer.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - imm_extend_unit_if.slave
//          in_valid/in_ready/in_data/in_mode : immediate push handshake
//          out_valid/out_ready/out_data      : result pop handshake (head of buffer)
//          out_count                         : number of buffered results (0..2)
//
// Modes: 00 zero-extend, 01 sign-extend, 10 sign-extend then shift left by one,
//        11 upper-load when IMM_EXT_LUI_EN is defined, otherwise identical to 00.
//
// Configuration macro: IMM_EXT_LUI_EN (enables the upper-load path for mode 11).
//
// Constraint: 1 <= IN_W < OUT_W; the interface must be built with the same widths.
module imm_extend_unit #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 16
) (
  input logic              clk,
  input logic              rst,
  imm_extend_unit_if.slave bus
);

  localparam int unsigned PadW = OUT_W - IN_W;

  // ---------------------------------------------------------------------------
  // Extension datapath (evaluated from the live inputs, captured only on push)
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] ext_zero;
  logic [OUT_W-1:0] ext_sign;
  logic [OUT_W-1:0] ext_shift;
  logic [OUT_W-1:0] ext_result;
`ifdef IMM_EXT_LUI_EN
  logic [OUT_W-1:0] ext_upper;
`endif

  always_comb begin
    ext_zero  = {{PadW{1'b0}}, bus.in_data};
    ext_sign  = {{PadW{bus.in_data[IN_W-1]}}, bus.in_data};
    // Shift drops the top sign copy; the result is truncated to OUT_W bits.
    ext_shift = {ext_sign[OUT_W-2:0], 1'b0};
`ifdef IMM_EXT_LUI_EN
    ext_upper = {bus.in_data, {PadW{1'b0}}};
`endif
  end

  always_comb begin
    ext_result = ext_zero;
    unique case (bus.in_mode)
      2'b00: ext_result = ext_zero;
      2'b01: ext_result = ext_sign;
      2'b10: ext_result = ext_shift;
`ifdef IMM_EXT_LUI_EN
      2'b11: ext_result = ext_upper;
`else
      2'b11: ext_result = ext_zero;
`endif
    endcase
  end

  // ---------------------------------------------------------------------------
  // 2-entry in-order result buffer
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] mem_q [2];
  logic [OUT_W-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic push;
  logic pop;
  logic in_ready;
  logic out_valid;

  // Both flags derive from registered state only, so neither handshake input
  // feeds back combinationally into the other side.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);

  // Gating with in_ready/out_valid makes push-when-full and pop-when-empty
  // impossible, so no extra guard is needed in the state update.
  assign push = bus.in_valid && in_ready;
  assign pop  = out_valid && bus.out_ready;

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = ext_result;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so that out_data reads zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: head of buffer straight from storage, no path from in_data
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_count = count_q;

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 Parameter IN_W, default 8, immediate input width; SHALL satisfy 1 <= IN_W < OUT_W.
REQ-002 Parameter OUT_W, default 16, extended result width.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  producer presents an immediate.
REQ-006 Port in_ready  output  1  unit can accept an immediate this cycle.
REQ-007 Port in_data  input  IN_W  raw immediate field.
REQ-008 Port in_mode  input  2  extension mode: 00 zero, 01 sign, 10 sign-shift-left-1, 11 upper-load.
REQ-009 Port out_valid  output  1  out_data holds a valid result.
REQ-010 Port out_ready  input  1  consumer accepts the result this cycle.
REQ-011 Port out_data  output  OUT_W  extended result, head of buffer.
REQ-012 Port out_count  output  2  number of buffered results (0..2).

Function
REQ-013 Push SHALL occur on a rising edge where in_valid && in_ready; pop SHALL occur where out_valid && out_ready.
REQ-014 Mode 00: result SHALL be {(OUT_W-IN_W) zeros, in_data}.
REQ-015 Mode 01: result SHALL be {(OUT_W-IN_W) copies of in_data[IN_W-1], in_data}.
REQ-016 Mode 10: result SHALL be the mode-01 result shifted left one bit, bit 0 = 0, truncated to OUT_W bits.
REQ-017 Mode 11: result SHALL be per REQ-029/REQ-030.
REQ-018 Extension SHALL be evaluated from in_data/in_mode at the push edge and stored; later input changes SHALL NOT alter stored results.
REQ-019 Results SHALL be held in a 2-entry in-order buffer; out_data SHALL be the oldest entry.
REQ-020 Latency: a result pushed at edge N SHALL appear with out_valid=1 from edge N onward when the buffer was empty; no combinational path from in_data to out_data.
REQ-021 in_ready SHALL equal (out_count != 2) and SHALL NOT depend combinationally on out_ready.
REQ-022 out_valid SHALL equal (out_count != 0).
REQ-023 Simultaneous push and pop at count 1 SHALL leave count 1 with the new entry at head; at count 2 no push occurs (REQ-021).
REQ-024 While out_valid && !out_ready, out_data SHALL remain stable.
REQ-025 Pop at count 0 and push at count 2 SHALL be impossible by construction; no state change.

Reset
REQ-026 On a rising edge with rst=1: out_count=0, out_valid=0, in_ready=1, buffer pointers=0, out_data=0; any in-flight push or pop that cycle SHALL be discarded.
REQ-027 rst SHALL take priority over all push/pop activity, including mid-stream with a full buffer.
REQ-028 First push SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-029 With macro IMM_EXT_LUI_EN defined, mode 11 SHALL produce {in_data, (OUT_W-IN_W) zeros}, truncated to its upper OUT_W bits when IN_W > OUT_W-IN_W is irrelevant (IN_W < OUT_W always fits).
REQ-030 Without IMM_EXT_LUI_EN, mode 11 SHALL behave exactly as mode 00 and no upper-load logic SHALL be synthesised.

Verification
REQ-031 IN_W=8, OUT_W=16, out_ready=1: push 0x80 mode 00 -> out_data 0x0080, out_valid next cycle; mode 01 -> 0xFF80; 0x7F mode 01 -> 0x007F.
REQ-032 Push 0x81 mode 10 -> 0xFF02; push 0x40 mode 10 -> 0x0080.
REQ-033 Push 0xAB mode 11 -> 0xAB00 with IMM_EXT_LUI_EN; 0x00AB without.
REQ-034 out_ready=0, push 0x01,0x02,0x03 on consecutive cycles -> count 1,2,2; in_ready=0 after second push; 0x03 not accepted; raise out_ready -> 0x0001 then 0x0002 in order, count 1 then 0.
REQ-035 Count 1, push 0x05 and pop same edge -> count stays 1, out_data 0x0005 next.
REQ-036 Count 2 with out_ready=0, assert rst one cycle while in_valid=1 -> count 0, out_valid=0, in_ready=1, out_data 0x0000; next push accepted normally.
